// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and sizing constants for the pipeline stage register
package pipe_pkg;

    localparam int MAX_DEPTH = 4;
    localparam int DATA_W_DEF = 27;
    // Wide enough to hold 2*MAX_DEPTH entries.
    localparam int OCC_W = $clog2(2 * MAX_DEPTH + 1);
    localparam int STALL_W = 16;

    typedef struct packed {
        logic [7:0] data1;
        logic [7:0] alu_reg;
        logic       write_reg;
        logic [2:0] reg1;
        logic [2:0] reg2;
        logic [3:0] opcode;
        logic [2:0] imm;
    } mem_wb_t;

endpackage

// File: rtl/pipe_skid_slot.sv
// rtl/pipe_skid_slot.sv - one main+skid entry with valid/ready on both sides
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    logic              main_valid;
    logic              skid_valid;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              accept;
    logic              drain;

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign count     = {1'b0, main_valid} + {1'b0, skid_valid};
    assign accept    = in_valid & in_ready;
    assign drain     = main_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (drain) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid || drain) begin
                main_data  <= in_data;
                main_valid <= 1'b1;
            end else begin
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end
        end else if (drain) begin
            main_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - DEPTH chained skid slots; PIPE_STALL_CNT_EN enables the stall counter
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [OCC_W-1:0]   occupancy,
    output logic [STALL_W-1:0] stall_cnt
);

    logic              link_valid [DEPTH+1];
    logic              link_ready [DEPTH+1];
    logic [DATA_W-1:0] link_data  [DEPTH+1];
    logic [1:0]        slot_cnt   [DEPTH];

    assign link_valid[0]     = in_valid;
    assign link_data[0]      = in_data;
    assign in_ready          = link_ready[0];
    assign out_valid         = link_valid[DEPTH];
    assign out_data          = link_data[DEPTH];
    assign link_ready[DEPTH] = out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        pipe_skid_slot #(.DATA_W(DATA_W)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush_i),
            .in_valid  (link_valid[i]),
            .in_ready  (link_ready[i]),
            .in_data   (link_data[i]),
            .out_valid (link_valid[i+1]),
            .out_ready (link_ready[i+1]),
            .out_data  (link_data[i+1]),
            .count     (slot_cnt[i])
        );
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(slot_cnt[i]);
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q;

    // Saturating; only reset clears it so flushes do not hide past backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && !(&stall_q)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
